board_reset_sequencer: RTL and testbench

//   Board-level reset source feeding the Hydrogen SoC io_reset input (upstream stage of the board top).

---
 rtl/board_reset_pkg.sv | 30 +++
 rtl/reset_debounce.sv | 49 ++++
 rtl/board_reset_sequencer.sv | 145 ++++++++++++++
 tb/tb_board_reset_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/board_reset_pkg.sv
// Shared types for the board reset sequencer: sequence states, reset-cause codes
// and the constant helpers used to size its counters.
package board_reset_pkg;

  typedef enum logic [1:0] {
    FLASH_RST  = 2'd0,
    FLASH_WAIT = 2'd1,
    SOC_HOLD   = 2'd2,
    RUN        = 2'd3
  } state_t;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_POR    = 2'b00;
  localparam cause_t CAUSE_BUTTON = 2'b01;
  localparam cause_t CAUSE_SW     = 2'b10;
  localparam cause_t CAUSE_WDOG   = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_debounce.sv
// Reset button conditioning: 2-FF synchroniser followed by a debounce counter.
// Emits the accepted (pressed) level and a one-cycle pulse on each accepted press.
module reset_debounce
  import board_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic io_clock,
  input  logic io_reset_n,
  input  logic io_button_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             sample_pressed;
  logic [CNT_W-1:0] cnt;

  assign sample_pressed = ~sync_q2;

  // cnt counts down the samples still needed that disagree with the accepted level.
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      sync_q1     <= 1'b1;
      sync_q2     <= 1'b1;
      pressed     <= 1'b0;
      press_pulse <= 1'b0;
      cnt         <= CNT_LOAD;
    end else begin
      sync_q1     <= io_button_n;
      sync_q2     <= sync_q1;
      press_pulse <= 1'b0;
      if (sample_pressed == pressed) begin
        cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
        pressed     <= sample_pressed;
        press_pulse <= sample_pressed;
        cnt         <= CNT_LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_reset_sequencer.sv
// Board reset source: orders flash reset, flash recovery and SoC hold after any reset cause.
// Optional watchdog (io_wdKick port, watchdog counter) is built when BOARD_RESET_WATCHDOG_EN is defined.
//
// state      | meaning
// FLASH_RST  | io_flashRst_n low, SoC held in reset
// FLASH_WAIT | flash released, waiting for it to recover
// SOC_HOLD   | final SoC hold; stretched while the button stays pressed
// RUN        | SoC released, triggers accepted
module board_reset_sequencer
  import board_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES       = 1000000,
  parameter int FLASH_RST_CYCLES      = 100,
  parameter int FLASH_RECOVERY_CYCLES = 3000,
  parameter int SOC_HOLD_CYCLES       = 16
`ifdef BOARD_RESET_WATCHDOG_EN
  ,
  parameter int WATCHDOG_CYCLES       = 134217728
`endif
) (
  input  logic       io_clock,
  input  logic       io_reset_n,
  input  logic       io_button_n,
  input  logic       io_swResetReq,
`ifdef BOARD_RESET_WATCHDOG_EN
  input  logic       io_wdKick,
`endif
  output logic       io_socReset,
  output logic       io_flashRst_n,
  output logic       io_ready,
  output logic [1:0] io_resetCause
);

  localparam int SEQ_W = cnt_width(max3(FLASH_RST_CYCLES, FLASH_RECOVERY_CYCLES, SOC_HOLD_CYCLES));

  localparam logic [SEQ_W-1:0] TC_FLASH_RST  = SEQ_W'(FLASH_RST_CYCLES - 1);
  localparam logic [SEQ_W-1:0] TC_FLASH_WAIT = SEQ_W'(FLASH_RECOVERY_CYCLES - 1);
  localparam logic [SEQ_W-1:0] TC_SOC_HOLD   = SEQ_W'(SOC_HOLD_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [SEQ_W-1:0] seq_cnt;
  logic [SEQ_W-1:0] seq_cnt_nxt;
  logic [SEQ_W-1:0] seq_tc;
  logic             seq_done;
  cause_t           cause_nxt;
  logic             btn_pressed;
  logic             btn_press;
  logic             wd_trig;

  reset_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .io_clock   (io_clock),
    .io_reset_n (io_reset_n),
    .io_button_n(io_button_n),
    .pressed    (btn_pressed),
    .press_pulse(btn_press)
  );

`ifdef BOARD_RESET_WATCHDOG_EN
  localparam int              WD_W  = cnt_width(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_TC = WD_W'(WATCHDOG_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_trig = (state == RUN) && (wd_cnt == WD_TC) && !io_wdKick;

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      wd_cnt <= '0;
    end else if (state_nxt != RUN || io_wdKick) begin
      wd_cnt <= '0;
    end else if (state == RUN) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_trig = 1'b0;
`endif

  // Elapsed-cycle counter shared by the timed states; restarts on every state change.
  always_comb begin
    seq_tc = '0;
    case (state)
      FLASH_RST:  seq_tc = TC_FLASH_RST;
      FLASH_WAIT: seq_tc = TC_FLASH_WAIT;
      SOC_HOLD:   seq_tc = TC_SOC_HOLD;
      default:    seq_tc = '0;
    endcase
  end

  assign seq_done = (seq_cnt == seq_tc);

  always_comb begin
    state_nxt = state;
    cause_nxt = io_resetCause;
    case (state)
      FLASH_RST:  if (seq_done) state_nxt = FLASH_WAIT;
      FLASH_WAIT: if (seq_done) state_nxt = SOC_HOLD;
      SOC_HOLD:   if (seq_done && !btn_pressed) state_nxt = RUN;
      RUN: begin
        if (btn_press) begin
          state_nxt = FLASH_RST;
          cause_nxt = CAUSE_BUTTON;
        end else if (wd_trig) begin
          state_nxt = FLASH_RST;
          cause_nxt = CAUSE_WDOG;
        end else if (io_swResetReq) begin
          state_nxt = FLASH_RST;
          cause_nxt = CAUSE_SW;
        end
      end
      default: state_nxt = FLASH_RST;
    endcase

    if (state_nxt != state) begin
      seq_cnt_nxt = '0;
    end else if (seq_done) begin
      seq_cnt_nxt = seq_cnt;
    end else begin
      seq_cnt_nxt = seq_cnt + 1'b1;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      state         <= FLASH_RST;
      seq_cnt       <= '0;
      io_socReset   <= 1'b1;
      io_flashRst_n <= 1'b0;
      io_ready      <= 1'b0;
      io_resetCause <= CAUSE_POR;
    end else begin
      state         <= state_nxt;
      seq_cnt       <= seq_cnt_nxt;
      io_socReset   <= (state_nxt != RUN);
      io_flashRst_n <= (state_nxt != FLASH_RST);
      io_ready      <= (state_nxt == RUN);
      io_resetCause <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_board_reset_sequencer.sv
// Directed bench for board_reset_sequencer with small timing parameters.
module tb_board_reset_sequencer;

  logic       io_clock;
  logic       io_reset_n;
  logic       io_button_n;
  logic       io_swResetReq;
`ifdef BOARD_RESET_WATCHDOG_EN
  logic       io_wdKick;
`endif
  logic       io_socReset;
  logic       io_flashRst_n;
  logic       io_ready;
  logic [1:0] io_resetCause;

  int n_pass  = 0;
  int n_total = 0;

  board_reset_sequencer #(
    .DEBOUNCE_CYCLES      (4),
    .FLASH_RST_CYCLES     (3),
    .FLASH_RECOVERY_CYCLES(5),
    .SOC_HOLD_CYCLES      (2)
`ifdef BOARD_RESET_WATCHDOG_EN
    ,
    .WATCHDOG_CYCLES      (20)
`endif
  ) dut (
    .io_clock     (io_clock),
    .io_reset_n   (io_reset_n),
    .io_button_n  (io_button_n),
    .io_swResetReq(io_swResetReq),
`ifdef BOARD_RESET_WATCHDOG_EN
    .io_wdKick    (io_wdKick),
`endif
    .io_socReset  (io_socReset),
    .io_flashRst_n(io_flashRst_n),
    .io_ready     (io_ready),
    .io_resetCause(io_resetCause)
  );

  initial io_clock = 1'b0;
  always #5 io_clock = ~io_clock;

  task automatic tick(input int n);
    repeat (n) @(negedge io_clock);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check_cause(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int waited;
    waited = 0;
    while (!io_ready && waited < budget) begin
      @(negedge io_clock);
      waited++;
    end
    check_bit(tag, io_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    io_reset_n    = 1'b0;
    io_button_n   = 1'b1;
    io_swResetReq = 1'b0;
`ifdef BOARD_RESET_WATCHDOG_EN
    io_wdKick     = 1'b0;
`endif
    tick(2);
    check_bit("rst_socReset", io_socReset, 1'b1);
    check_bit("rst_flashRst_n", io_flashRst_n, 1'b0);
    check_bit("rst_ready", io_ready, 1'b0);
    check_cause("rst_cause", io_resetCause, 2'b00);

    // Power-on sequence: 3 cycles flash reset, socReset falls 7 cycles after flash release.
    io_reset_n = 1'b1;
    tick(1);
    check_bit("t1_flash_low_c1", io_flashRst_n, 1'b0);
    tick(1);
    check_bit("t1_flash_low_c2", io_flashRst_n, 1'b0);
    tick(1);
    check_bit("t1_flash_high", io_flashRst_n, 1'b1);
    check_bit("t1_soc_held", io_socReset, 1'b1);
    tick(6);
    check_bit("t1_soc_still_held", io_socReset, 1'b1);
    tick(1);
    check_bit("t1_soc_release", io_socReset, 1'b0);
    check_bit("t1_ready", io_ready, 1'b1);
    check_cause("t1_cause", io_resetCause, 2'b00);

    // Short bounce is rejected; a 6-cycle press restarts the sequence.
    io_button_n = 1'b0;
    tick(3);
    io_button_n = 1'b1;
    tick(12);
    check_bit("t2_short_press_ready", io_ready, 1'b1);
    check_bit("t2_short_press_soc", io_socReset, 1'b0);
    io_button_n = 1'b0;
    tick(6);
    check_bit("t2_before_trigger", io_socReset, 1'b0);
    io_button_n = 1'b1;
    tick(1);
    check_bit("t2_soc", io_socReset, 1'b1);
    check_bit("t2_flash", io_flashRst_n, 1'b0);
    check_bit("t2_ready", io_ready, 1'b0);
    check_cause("t2_cause", io_resetCause, 2'b01);
    tick(9);
    check_bit("t2_not_yet_run", io_ready, 1'b0);
    tick(1);
    check_bit("t2_run", io_ready, 1'b1);
    check_cause("t2_cause_hold", io_resetCause, 2'b01);

    // Software request in RUN, then a request during FLASH_WAIT which must be ignored.
    io_swResetReq = 1'b1;
    tick(1);
    io_swResetReq = 1'b0;
    check_bit("t3_soc", io_socReset, 1'b1);
    check_bit("t3_flash", io_flashRst_n, 1'b0);
    check_bit("t3_ready", io_ready, 1'b0);
    check_cause("t3_cause", io_resetCause, 2'b10);
    tick(3);
    check_bit("t3_flash_high", io_flashRst_n, 1'b1);
    io_swResetReq = 1'b1;
    tick(1);
    io_swResetReq = 1'b0;
    check_bit("t4_sw_in_wait_flash", io_flashRst_n, 1'b1);
    check_cause("t4_sw_in_wait_cause", io_resetCause, 2'b10);
    tick(5);
    check_bit("t3_not_yet_run", io_ready, 1'b0);
    tick(1);
    check_bit("t3_run", io_ready, 1'b1);

    // Button press pulse and software request in the same cycle: button wins.
    io_button_n = 1'b0;
    tick(6);
    io_swResetReq = 1'b1;
    io_button_n   = 1'b1;
    tick(1);
    io_swResetReq = 1'b0;
    check_cause("t4_priority_cause", io_resetCause, 2'b01);
    check_bit("t4_priority_soc", io_socReset, 1'b1);
    wait_ready(20, "t4_recover");
    check_cause("t4_cause_hold", io_resetCause, 2'b01);

    // Button held through a software-started sequence stretches SOC_HOLD; press edge ignored.
    io_swResetReq = 1'b1;
    io_button_n   = 1'b0;
    tick(1);
    io_swResetReq = 1'b0;
    check_cause("t5_cause_sw", io_resetCause, 2'b10);
    tick(20);
    check_bit("t5_held_soc", io_socReset, 1'b1);
    check_bit("t5_held_ready", io_ready, 1'b0);
    check_cause("t5_held_cause", io_resetCause, 2'b10);
    io_button_n = 1'b1;
    tick(6);
    check_bit("t5_before_release", io_ready, 1'b0);
    tick(1);
    check_bit("t5_released", io_ready, 1'b1);
    check_cause("t5_cause_final", io_resetCause, 2'b10);

`ifdef BOARD_RESET_WATCHDOG_EN
    // Regular kicks keep the SoC running; silence for 20 cycles fires the watchdog.
    repeat (5) begin
      tick(9);
      io_wdKick = 1'b1;
      tick(1);
      io_wdKick = 1'b0;
    end
    check_bit("t6_kicked_ready", io_ready, 1'b1);
    check_bit("t6_kicked_soc", io_socReset, 1'b0);
    tick(19);
    check_bit("t6_before_timeout", io_socReset, 1'b0);
    tick(1);
    check_bit("t6_timeout_soc", io_socReset, 1'b1);
    check_cause("t6_timeout_cause", io_resetCause, 2'b11);
`endif

    // io_reset_n pulsed mid-FLASH_WAIT returns outputs to reset values at once.
    wait_ready(30, "t7_run_before");
    io_swResetReq = 1'b1;
    tick(1);
    io_swResetReq = 1'b0;
    check_cause("t7_cause_sw", io_resetCause, 2'b10);
    tick(5);
    check_bit("t7_in_wait", io_flashRst_n, 1'b1);
    io_reset_n = 1'b0;
    #1;
    check_bit("t7_async_soc", io_socReset, 1'b1);
    check_bit("t7_async_flash", io_flashRst_n, 1'b0);
    check_bit("t7_async_ready", io_ready, 1'b0);
    check_cause("t7_async_cause", io_resetCause, 2'b00);
    tick(1);
    io_reset_n = 1'b1;
    tick(3);
    check_bit("t7_flash_high", io_flashRst_n, 1'b1);
    tick(7);
    check_bit("t7_run", io_ready, 1'b1);
    check_cause("t7_cause_por", io_resetCause, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
